// File: rtl/debounce_pkg.sv
// Shared types and constants for the push-button debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW,
        WAIT_HIGH,
        STABLE_HIGH,
        WAIT_LOW
    } debounce_state_e;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/debounce_timer.sv
// Stable-window timer: counts enabled cycles and flags the last cycle of the window.
module debounce_timer #(
    parameter int MAX_COUNT = 10,
    parameter int DW        = $clog2(MAX_COUNT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [DW-1:0] count;

    assign expired = (count == DW'(MAX_COUNT - 1));

    // Saturates at the expiry value so a window can never wrap back to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + DW'(1);
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: 2-FF sync, stable-window FSM, clean level and press pulse.
// Define DEBOUNCER_FALL_PULSE_EN to add the btn_fall release pulse output.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter real  FREQUENCY  = 50_000_000,
    parameter real  DELAY      = 0.03,
    parameter int   MAX_COUNT  = int'(DELAY * FREQUENCY),
    parameter int   DW         = $clog2(MAX_COUNT),
    parameter logic ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
`ifdef DEBOUNCER_FALL_PULSE_EN
    output logic btn_rise,
    output logic btn_fall
`else
    output logic btn_rise
`endif
);

    if (MAX_COUNT < 2) begin : g_bad_count
        $error("button_debouncer: MAX_COUNT must be at least 2");
    end

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync;
    debounce_state_e        state;
    debounce_state_e        next_state;
    logic                   timer_clear;
    logic                   timer_enable;
    logic                   expired;
    logic                   rise_next;
    logic                   level_next;
`ifdef DEBOUNCER_FALL_PULSE_EN
    logic                   fall_next;
`endif

    // Flops hold the polarity-normalised pin; reset loads "released" so no false press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], btn_in ^ ACTIVE_LOW};
        end
    end

    assign sync = sync_ff[SYNC_STAGES-1];

    debounce_timer #(
        .MAX_COUNT(MAX_COUNT),
        .DW       (DW)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE_LOW;
        end else begin
            state <= next_state;
        end
    end

    // Abort on a sync change is checked before expiry, so the expiry edge must still see a stable pin.
    always_comb begin
        next_state   = state;
        timer_clear  = 1'b1;
        timer_enable = 1'b0;
        rise_next    = 1'b0;
`ifdef DEBOUNCER_FALL_PULSE_EN
        fall_next    = 1'b0;
`endif
        case (state)
            IDLE_LOW: begin
                if (sync) begin
                    next_state = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                timer_clear  = 1'b0;
                timer_enable = 1'b1;
                if (!sync) begin
                    next_state = IDLE_LOW;
                end else if (expired) begin
                    next_state = STABLE_HIGH;
                    rise_next  = 1'b1;
                end
            end
            STABLE_HIGH: begin
                if (!sync) begin
                    next_state = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                timer_clear  = 1'b0;
                timer_enable = 1'b1;
                if (sync) begin
                    next_state = STABLE_HIGH;
                end else if (expired) begin
                    next_state = IDLE_LOW;
`ifdef DEBOUNCER_FALL_PULSE_EN
                    fall_next  = 1'b1;
`endif
                end
            end
            default: begin
                next_state = IDLE_LOW;
            end
        endcase
    end

    assign level_next = (next_state == STABLE_HIGH) || (next_state == WAIT_LOW);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_level <= 1'b0;
            btn_rise  <= 1'b0;
`ifdef DEBOUNCER_FALL_PULSE_EN
            btn_fall  <= 1'b0;
`endif
        end else begin
            btn_level <= level_next;
            btn_rise  <= rise_next;
`ifdef DEBOUNCER_FALL_PULSE_EN
            btn_fall  <= fall_next;
`endif
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: directed edge-exact checks plus randomized pin activity.
module tb_button_debouncer;

    localparam real FREQUENCY = 1000.0;
    localparam real DELAY     = 0.01;
    localparam int  WINDOW    = 10;

    logic clk    = 1'b0;
    logic rst    = 1'b0;
    logic btn_in = 1'b1;
    logic btn_level;
    logic btn_rise;
`ifdef DEBOUNCER_FALL_PULSE_EN
    logic btn_fall;
`endif

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    button_debouncer #(
        .FREQUENCY (FREQUENCY),
        .DELAY     (DELAY),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_in),
        .btn_level(btn_level),
`ifdef DEBOUNCER_FALL_PULSE_EN
        .btn_rise (btn_rise),
        .btn_fall (btn_fall)
`else
        .btn_rise (btn_rise)
`endif
    );

    // Reference: the pressed level reaches the decision point two edges after sampling;
    // the clean level flips once the opposite value has been seen WINDOW+1 edges in a row.
    logic [1:0] pin_hist;
    logic       m_sync;
    logic       run_val;
    int         run_len;
    logic       m_level;
    logic       m_rise;
    logic       m_fall;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pin_hist = 2'b00;
            m_sync   = 1'b0;
            run_val  = 1'b0;
            run_len  = 0;
            m_level  = 1'b0;
            m_rise   = 1'b0;
            m_fall   = 1'b0;
        end else begin
            m_sync   = pin_hist[1];
            pin_hist = {pin_hist[0], ~btn_in};
            if (m_sync == run_val) begin
                run_len++;
            end else begin
                run_val = m_sync;
                run_len = 1;
            end
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (m_sync != m_level && run_len == WINDOW + 1) begin
                m_level = m_sync;
                m_rise  = m_sync;
                m_fall  = ~m_sync;
            end
        end
    end

    task automatic check_output(input string name, input logic act, input logic exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #3;
        check_output("model_level", btn_level, m_level);
        check_output("model_rise", btn_rise, m_rise);
`ifdef DEBOUNCER_FALL_PULSE_EN
        check_output("model_fall", btn_fall, m_fall);
`endif
    end

    task automatic apply_stimulus(input logic value, input int cycles);
        @(negedge clk);
        btn_in = value;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic step_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic count_rises(input int edges, output int rises);
        rises = 0;
        for (int i = 0; i < edges; i++) begin
            step_edge();
            if (btn_rise) rises++;
        end
    endtask

    initial begin
        int rises;
        int val;
        int len;

        // Reset held with the pin released, then idle quietly.
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_level", btn_level, 1'b0);
        check_output("reset_rise", btn_rise, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        count_rises(50, rises);
        check_output("idle_no_rise", rises == 0, 1'b1);
        check_output("idle_level", btn_level, 1'b0);

        // Clean press: pulse exactly on edge WINDOW+3.
        apply_stimulus(1'b0, 0);
        repeat (WINDOW + 2) step_edge();
        check_output("press_edge12_rise", btn_rise, 1'b0);
        check_output("press_edge12_level", btn_level, 1'b0);
        step_edge();
        check_output("press_edge13_rise", btn_rise, 1'b1);
        check_output("press_edge13_level", btn_level, 1'b1);
        step_edge();
        check_output("press_edge14_rise", btn_rise, 1'b0);
        count_rises(30, rises);
        check_output("held_no_repeat", rises == 0, 1'b1);
        check_output("held_level", btn_level, 1'b1);

        // Release: level drops on edge WINDOW+3.
        apply_stimulus(1'b1, 0);
        repeat (WINDOW + 2) step_edge();
        check_output("release_edge12_level", btn_level, 1'b1);
        step_edge();
        check_output("release_edge13_level", btn_level, 1'b0);
`ifdef DEBOUNCER_FALL_PULSE_EN
        check_output("release_edge13_fall", btn_fall, 1'b1);
        step_edge();
        check_output("release_edge14_fall", btn_fall, 1'b0);
`endif
        repeat (20) @(negedge clk);

        // Bounce: low 5, high 2, then steady low.
        apply_stimulus(1'b0, 5);
        btn_in = 1'b1;
        repeat (2) @(negedge clk);
        btn_in = 1'b0;
        count_rises(WINDOW + 2, rises);
        check_output("bounce_no_early_rise", rises == 0, 1'b1);
        step_edge();
        check_output("bounce_edge13_rise", btn_rise, 1'b1);
        apply_stimulus(1'b1, 30);

        // Pin released exactly on the expiry edge: no press accepted.
        apply_stimulus(1'b0, WINDOW);
        btn_in = 1'b1;
        count_rises(20, rises);
        check_output("expiry_abort_no_rise", rises == 0, 1'b1);
        check_output("expiry_abort_level", btn_level, 1'b0);

        // One more sampled cycle of press is just enough.
        apply_stimulus(1'b0, WINDOW + 1);
        btn_in = 1'b1;
        step_edge();
        check_output("min_press_edge12_rise", btn_rise, 1'b0);
        step_edge();
        check_output("min_press_edge13_rise", btn_rise, 1'b1);
        repeat (40) @(negedge clk);

        // Reset mid-window, pin still pressed afterwards.
        apply_stimulus(1'b0, 0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("midreset_level", btn_level, 1'b0);
        check_output("midreset_rise", btn_rise, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (WINDOW + 2) step_edge();
        check_output("postreset_edge12_rise", btn_rise, 1'b0);
        step_edge();
        check_output("postreset_edge13_rise", btn_rise, 1'b1);
        check_output("postreset_edge13_level", btn_level, 1'b1);
        apply_stimulus(1'b1, 30);

        // Randomized pin activity with occasional resets.
        for (int seg = 0; seg < 160; seg++) begin
            if ($urandom_range(0, 15) == 0) begin
                @(negedge clk);
                rst = 1'b0;
                repeat (2) @(negedge clk);
                rst = 1'b1;
            end
            val = $urandom_range(0, 1);
            len = $urandom_range(1, 25);
            apply_stimulus(val[0], len);
        end

        apply_stimulus(1'b1, 30);
        #4;
        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
